cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_EU, default 4: number of execution units competing for the common data bus.
REQ-002 SHALL have parameter DATA_W, default 64: width of the opaque broadcast payload.
REQ-003 SHALL have parameter EBR_W, default 4: width of the branch (EBR) mask.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port late_flush, input, 1: pipeline flush; kills all in-flight broadcasts.
REQ-007 SHALL have port eu_req, input, NUM_EU: EU i holds a valid result at its output stage.
REQ-008 SHALL have port eu_data, input, NUM_EU*DATA_W: payload of EU i in slice [i*DATA_W +: DATA_W].
REQ-009 SHALL have port eu_ebr_mask, input, NUM_EU*EBR_W: branch mask of EU i's result.
REQ-010 SHALL have port eu_stall, output, NUM_EU: backpressure to EU i (the EU's bc_stall).
REQ-011 SHALL have port bra_done, input, 1: a branch resolves this cycle.
REQ-012 SHALL have port bra_mispredict, input, 1: the resolving branch mispredicted.
REQ-013 SHALL have port bra_id, input, EBR_W: one-hot tag of the resolving branch.
REQ-014 SHALL have port cdb_valid, output, 1: registered broadcast valid.
REQ-015 SHALL have port cdb_data, output, DATA_W: registered broadcast payload.
REQ-016 SHALL have port cdb_ebr_mask, output, EBR_W: registered broadcast branch mask.
REQ-017 SHALL have port cdb_src, output, $clog2(NUM_EU): index of the EU that won arbitration.

Function
REQ-018 SHALL mark request i as killed when bra_done && bra_mispredict && |(eu_ebr_mask[i] & bra_id) is true; a killed request SHALL be treated as not requesting.
REQ-019 SHALL grant at most one live request per cycle using round-robin: the grant goes to the first live requester at index ptr+1, ptr+2, ... with wrap-around modulo NUM_EU.
REQ-020 SHALL update ptr to the granted index on the clock edge after a grant and SHALL leave ptr unchanged when no grant occurs.
REQ-021 SHALL drive eu_stall[i] combinationally to 1 when request i is live and not granted, and to 0 otherwise (granted, not requesting, or killed).
REQ-022 SHALL rely on a stalled EU holding eu_req, eu_data and eu_ebr_mask stable; the arbiter itself SHALL store nothing for ungranted requests.
REQ-023 SHALL capture the granted payload into the output register on the clock edge, giving exactly 1 cycle of grant-to-cdb_valid latency.
REQ-024 SHALL capture the granted mask with bit bra_id cleared when bra_done is high in the grant cycle.
REQ-025 SHALL hold cdb_valid high for exactly one cycle per grant, with no backpressure on the CDB output.
REQ-026 SHALL clear cdb_valid on the next edge when no grant occurs; cdb_data and cdb_src are don't-care while cdb_valid = 0.
REQ-027 SHALL drive cdb_ebr_mask combinationally as the register value with bit bra_id cleared when bra_done is high.
REQ-028 SHALL drive cdb_valid combinationally to 0 while bra_done && bra_mispredict and the registered mask intersects bra_id.
REQ-029 SHALL, while late_flush is high, force eu_stall to all zeros, make no grant, clear cdb_valid on the next edge, hold ptr, and combinationally gate cdb_valid to 0 in that same cycle.
REQ-030 SHALL produce no grant and all-zero eu_stall when no live request exists.

Reset
REQ-031 SHALL, on rst, set cdb_valid to 0 and ptr to NUM_EU-1 so that EU 0 has first priority after reset; eu_stall SHALL read all zeros during rst.
REQ-032 SHALL, when rst is asserted mid-broadcast, drop the broadcast; cdb_valid SHALL be 0 in the cycle after the reset edge.

Verification
REQ-033 SHALL verify: after reset, eu_req=4'b1111 held for 4 cycles -> grants in order 0,1,2,3; cdb_src sequence 0,1,2,3 one cycle later each; eu_stall on the first cycle = 4'b1110.
REQ-034 SHALL verify: ptr=1 with eu_req=4'b1001 -> grant EU3 and eu_stall=4'b0001; the next cycle grants EU0 (wrap-around).
REQ-035 SHALL verify: EU2 alone requests with mask 4'b0100 while bra_done=1, bra_mispredict=1, bra_id=4'b0100 -> no grant, eu_stall=0, cdb_valid=0 the next cycle.
REQ-036 SHALL verify: cdb_valid=1 with mask 4'b0011 and bra_done=1, bra_mispredict=0, bra_id=4'b0001 -> cdb_ebr_mask reads 4'b0010 the same cycle; the same inputs with bra_mispredict=1 -> cdb_valid reads 0.
REQ-037 SHALL verify: late_flush pulsed with eu_req=4'b0110 and cdb_valid=1 -> cdb_valid=0 that cycle and the next, eu_stall=0, ptr unchanged.
REQ-038 SHALL verify: rst asserted while cdb_valid=1 -> cdb_valid=0 after the edge, and the first subsequent grant with eu_req=4'b1111 goes to EU0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus (CDB).
//
// Execution units present finished results on eu_req/eu_data/eu_ebr_mask. One live request
// per cycle wins and is captured into the CDB output register. The winner is broadcast one
// cycle later. Requests that lose are stalled through eu_stall and must hold their inputs.
// Requests and broadcasts under a mispredicted branch are squashed.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   late_flush         kills every request and the broadcast in the current cycle
//   eu_req             per-EU result valid
//   eu_data            per-EU payload, slice [i*DATA_W +: DATA_W]
//   eu_ebr_mask        per-EU branch mask, slice [i*EBR_W +: EBR_W]
//   eu_stall           per-EU backpressure (live but not granted)
//   bra_done           a branch resolves this cycle
//   bra_mispredict     the resolving branch mispredicted
//   bra_id             one-hot tag of the resolving branch
//   cdb_valid          broadcast valid (register, squashed combinationally)
//   cdb_data           broadcast payload
//   cdb_ebr_mask       broadcast branch mask with the resolving branch bit cleared
//   cdb_src            index of the EU being broadcast
module cdb_arbiter #(
    parameter int unsigned NUM_EU = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned EBR_W  = 4,
    localparam int unsigned SRC_W = (NUM_EU > 1) ? $clog2(NUM_EU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     late_flush,
    input  logic [NUM_EU-1:0]        eu_req,
    input  logic [NUM_EU*DATA_W-1:0] eu_data,
    input  logic [NUM_EU*EBR_W-1:0]  eu_ebr_mask,
    output logic [NUM_EU-1:0]        eu_stall,
    input  logic                     bra_done,
    input  logic                     bra_mispredict,
    input  logic [EBR_W-1:0]         bra_id,
    output logic                     cdb_valid,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [EBR_W-1:0]         cdb_ebr_mask,
    output logic [SRC_W-1:0]         cdb_src
);

    logic [NUM_EU-1:0] live;
    logic [NUM_EU-1:0] gnt_oh;
    logic              gnt_valid;
    logic [SRC_W-1:0]  gnt_idx;
    logic [EBR_W-1:0]  gnt_mask;

    logic              valid_q, valid_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q;
    logic [EBR_W-1:0]  mask_q;
    logic [SRC_W-1:0]  src_q;

    // Live requests: not killed by a mispredict, and nothing is live under flush or reset.
    always_comb begin
        live = '0;
        for (int i = 0; i < int'(NUM_EU); i++) begin
            live[i] = eu_req[i] & ~late_flush & ~rst
                      & ~(bra_done & bra_mispredict
                          & |(eu_ebr_mask[i*EBR_W +: EBR_W] & bra_id));
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        int idx;
        logic [SRC_W-1:0] idx_w;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        for (int k = 1; k <= int'(NUM_EU); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NUM_EU)) begin
                idx = idx - int'(NUM_EU);
            end
            idx_w = SRC_W'(idx);
            if (!gnt_valid && live[idx_w]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx_w;
            end
        end
        if (gnt_valid) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_mask = eu_ebr_mask[gnt_idx*EBR_W +: EBR_W];
        if (bra_done) begin
            gnt_mask = gnt_mask & ~bra_id;
        end
    end

    assign eu_stall = live & ~gnt_oh;
    assign valid_d  = gnt_valid;
    assign ptr_d    = gnt_valid ? gnt_idx : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ptr_q   <= SRC_W'(NUM_EU - 1);
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    // Payload registers need no reset; they are ignored while valid_q is low.
    always_ff @(posedge clk) begin
        if (gnt_valid) begin
            data_q <= eu_data[gnt_idx*DATA_W +: DATA_W];
            mask_q <= gnt_mask;
            src_q  <= gnt_idx;
        end
    end

    // A branch resolving in the broadcast cycle still has to be reflected on the bus.
    assign cdb_ebr_mask = bra_done ? (mask_q & ~bra_id) : mask_q;
    assign cdb_valid    = valid_q & ~late_flush
                          & ~(bra_done & bra_mispredict & |(mask_q & bra_id));
    assign cdb_data     = data_q;
    assign cdb_src      = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a random phase, all checked
// against a scoreboard of expected broadcasts built from a small behavioural model.
module tb_cdb_arbiter;

    localparam int NUM_EU = 4;
    localparam int DATA_W = 64;
    localparam int EBR_W  = 4;

    logic                     clk;
    logic                     rst;
    logic                     late_flush;
    logic [NUM_EU-1:0]        eu_req;
    logic [NUM_EU*DATA_W-1:0] eu_data;
    logic [NUM_EU*EBR_W-1:0]  eu_ebr_mask;
    logic [NUM_EU-1:0]        eu_stall;
    logic                     bra_done;
    logic                     bra_mispredict;
    logic [EBR_W-1:0]         bra_id;
    logic                     cdb_valid;
    logic [DATA_W-1:0]        cdb_data;
    logic [EBR_W-1:0]         cdb_ebr_mask;
    logic [1:0]               cdb_src;

    cdb_arbiter #(
        .NUM_EU(NUM_EU),
        .DATA_W(DATA_W),
        .EBR_W (EBR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .late_flush    (late_flush),
        .eu_req        (eu_req),
        .eu_data       (eu_data),
        .eu_ebr_mask   (eu_ebr_mask),
        .eu_stall      (eu_stall),
        .bra_done      (bra_done),
        .bra_mispredict(bra_mispredict),
        .bra_id        (bra_id),
        .cdb_valid     (cdb_valid),
        .cdb_data      (cdb_data),
        .cdb_ebr_mask  (cdb_ebr_mask),
        .cdb_src       (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [63:0] data;
        logic [3:0]  mask;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mptr;

    logic [3:0]  snap_stall;
    logic        snap_valid;
    logic [3:0]  snap_mask;
    logic [1:0]  snap_src;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check one cycle at the negedge against the model, then advance past the next posedge.
    task automatic run_cycle();
        logic [3:0] live;
        logic [3:0] gnt_oh;
        logic [3:0] m;
        logic       gv;
        logic       ev;
        int         gidx;
        int         j;
        exp_t       e;
        @(negedge clk);
        snap_stall = eu_stall;
        snap_valid = cdb_valid;
        snap_mask  = cdb_ebr_mask;
        snap_src   = cdb_src;
        for (int i = 0; i < NUM_EU; i++) begin
            m = eu_ebr_mask[i*EBR_W +: EBR_W];
            live[i] = eu_req[i] && !late_flush && !rst
                      && !(bra_done && bra_mispredict && ((m & bra_id) != 4'b0));
        end
        gv = 1'b0;
        gidx = 0;
        for (int k = 1; k <= NUM_EU; k++) begin
            j = (mptr + k) % NUM_EU;
            if (!gv && live[j]) begin
                gv = 1'b1;
                gidx = j;
            end
        end
        gnt_oh = gv ? (4'b0001 << gidx) : 4'b0000;
        check_val("eu_stall", eu_stall, live & ~gnt_oh);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ev = !late_flush && !(bra_done && bra_mispredict && ((e.mask & bra_id) != 4'b0));
            check_val("cdb_valid", cdb_valid, ev);
            check_val("cdb_ebr_mask", cdb_ebr_mask, bra_done ? (e.mask & ~bra_id) : e.mask);
            if (ev) begin
                check_val("cdb_src", cdb_src, e.src);
                check_val("cdb_data", cdb_data, e.data);
            end
        end else begin
            check_val("cdb_valid_idle", cdb_valid, 1'b0);
        end
        if (rst) begin
            mptr = NUM_EU - 1;
        end else if (gv) begin
            e.src  = gidx;
            e.data = eu_data[gidx*DATA_W +: DATA_W];
            m      = eu_ebr_mask[gidx*EBR_W +: EBR_W];
            e.mask = bra_done ? (m & ~bra_id) : m;
            sb_q.push_back(e);
            mptr = gidx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_data();
        for (int i = 0; i < NUM_EU; i++) begin
            eu_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
        end
    endtask

    initial begin
        rst = 1'b1;
        late_flush = 1'b0;
        eu_req = 4'b1111;
        eu_ebr_mask = '0;
        bra_done = 1'b0;
        bra_mispredict = 1'b0;
        bra_id = 4'b0000;
        new_data();

        // Reset: stalls held low, cdb_valid cleared.
        @(negedge clk);
        check_val("rst_stall0", eu_stall, 4'b0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_stall1", eu_stall, 4'b0000);
        check_val("rst_valid", cdb_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mptr = NUM_EU - 1;
        sb_q.delete();

        // All four request: grants 0,1,2,3, each broadcast one cycle later.
        for (int c = 0; c < 5; c++) begin
            if (c == 4) eu_req = 4'b0000;
            run_cycle();
            if (c == 0) check_val("all_req_stall", snap_stall, 4'b1110);
            if (c >= 1) begin
                check_val("all_req_valid", snap_valid, 1'b1);
                check_val("all_req_src", snap_src, c - 1);
            end
        end

        // Wrap-around: ptr=1, EU0 and EU3 request -> EU3 first, then EU0.
        eu_req = 4'b0010;
        run_cycle();
        eu_req = 4'b1001;
        new_data();
        run_cycle();
        check_val("wrap_stall", snap_stall, 4'b0001);
        eu_req = 4'b0001;
        run_cycle();
        check_val("wrap_src3", snap_src, 2'd3);
        eu_req = 4'b0000;
        run_cycle();
        check_val("wrap_src0", snap_src, 2'd0);
        check_val("wrap_valid", snap_valid, 1'b1);

        // Killed request: EU2 under the mispredicted branch.
        eu_req = 4'b0100;
        eu_ebr_mask[2*EBR_W +: EBR_W] = 4'b0100;
        bra_done = 1'b1;
        bra_mispredict = 1'b1;
        bra_id = 4'b0100;
        run_cycle();
        check_val("kill_stall", snap_stall, 4'b0000);
        eu_req = 4'b0000;
        bra_done = 1'b0;
        bra_mispredict = 1'b0;
        run_cycle();
        check_val("kill_valid", snap_valid, 1'b0);

        // Broadcast-cycle branch resolution: mask clearing, then squash on mispredict.
        eu_req = 4'b0001;
        eu_ebr_mask[0 +: EBR_W] = 4'b0011;
        run_cycle();
        eu_req = 4'b0000;
        bra_done = 1'b1;
        bra_id = 4'b0001;
        run_cycle();
        check_val("resolve_mask", snap_mask, 4'b0010);
        check_val("resolve_valid", snap_valid, 1'b1);
        bra_done = 1'b0;
        eu_req = 4'b0001;
        run_cycle();
        eu_req = 4'b0000;
        bra_done = 1'b1;
        bra_mispredict = 1'b1;
        run_cycle();
        check_val("squash_valid", snap_valid, 1'b0);
        bra_done = 1'b0;
        bra_mispredict = 1'b0;
        bra_id = 4'b0000;
        eu_ebr_mask = '0;

        // Late flush: broadcast dropped, no grant, ptr held at 0.
        eu_req = 4'b0001;
        run_cycle();
        late_flush = 1'b1;
        eu_req = 4'b0110;
        run_cycle();
        check_val("flush_valid0", snap_valid, 1'b0);
        check_val("flush_stall", snap_stall, 4'b0000);
        late_flush = 1'b0;
        eu_req = 4'b0000;
        run_cycle();
        check_val("flush_valid1", snap_valid, 1'b0);
        eu_req = 4'b0110;
        run_cycle();
        check_val("flush_ptr_stall", snap_stall, 4'b0100);
        eu_req = 4'b0000;
        run_cycle();
        check_val("flush_ptr_src", snap_src, 2'd1);

        // Reset mid-broadcast: broadcast dropped, EU0 first afterwards.
        eu_req = 4'b0100;
        run_cycle();
        eu_req = 4'b0000;
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        eu_req = 4'b1111;
        run_cycle();
        check_val("rst_mid_valid", snap_valid, 1'b0);
        check_val("rst_mid_stall", snap_stall, 4'b1110);
        eu_req = 4'b0000;
        run_cycle();
        check_val("rst_mid_src", snap_src, 2'd0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            eu_req = 4'($urandom);
            new_data();
            eu_ebr_mask = 16'($urandom);
            bra_done = ($urandom_range(0, 2) == 0);
            bra_mispredict = $urandom_range(0, 1) == 1;
            bra_id = 4'b0001 << $urandom_range(0, 3);
            late_flush = ($urandom_range(0, 14) == 0);
            rst = ($urandom_range(0, 49) == 0);
            run_cycle();
        end
        rst = 1'b0;
        late_flush = 1'b0;
        eu_req = 4'b0000;
        bra_done = 1'b0;
        run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
